// File: rtl/exec_controller_pkg.sv
// exec_controller_pkg: shared sequencer state, opcode and instruction types.
// Rev 1.0 - initial release.
`default_nettype none

package exec_controller_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    SRST    = 3'd0,
    SREAD   = 3'd1,
    SLOAD1  = 3'd2,
    SLOAD2  = 3'd3,
    SCALC   = 3'd4,
    SWRITE  = 3'd5,
    SFINISH = 3'd6,
    SERR    = 3'd7
  } SequencerState;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_MUL  = 4'h4,
    OP_DIV  = 4'h5,
    OP_JMP  = 4'h6,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [7:0] imm;
  } instr_t;

endpackage

`default_nettype wire

// File: rtl/exec_controller_muldiv.sv
// exec_muldiv: iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Rev 1.0 - initial release.
`default_nettype none

module exec_muldiv #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              is_div,
  input  logic              step,
  input  logic              clr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              r_run;
  logic              r_div;
  logic              r_done;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_x;    // multiplier (mul) or dividend/quotient (div)
  logic [DATA_W-1:0] r_y;    // multiplicand (mul) or divisor (div)
  logic [DATA_W:0]   r_acc;  // product (mul) or partial remainder (div)

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;
  logic            w_neg;

  assign w_shift = {r_acc[DATA_W-1:0], r_x[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_y};
  assign w_neg   = w_diff[DATA_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run  <= 1'b0;
      r_div  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_acc  <= '0;
    end else if (clr) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_div  <= is_div;
      r_x    <= is_div ? a : b;
      r_y    <= is_div ? b : a;
      r_acc  <= '0;
    end else if (step && r_run) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(DATA_W - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
      if (r_div) begin
        r_acc <= w_neg ? w_shift : w_diff;
        r_x   <= {r_x[DATA_W-2:0], ~w_neg};
      end else begin
        if (r_x[0]) r_acc <= r_acc + {1'b0, r_y};
        r_x <= r_x >> 1;
        r_y <= r_y << 1;
      end
    end
  end

  assign busy   = r_run;
  assign done   = r_done;
  assign result = r_div ? r_x : r_acc[DATA_W-1:0];

endmodule

`default_nettype wire

// File: rtl/exec_controller.sv
// exec_controller: PC, IR, 4-entry register file and ALU driven by the CPU sequencer state.
// Optional iterative MUL/DIV under macro EXEC_MULDIV_EN. Rev 1.0 - initial release.
`default_nettype none

module exec_controller
  import exec_controller_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  SequencerState     seq_q,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic              nxt_line,
  output logic              err,
  output logic              finish,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

`ifdef EXEC_MULDIV_EN
  localparam bit c_MD_EN = 1'b1;
`else
  localparam bit c_MD_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] r_pc;
  instr_t            r_ir;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_rf [4];

  logic [3:0]        w_op;
  logic              w_legal;
  logic              w_is_md;
  logic              w_writes;
  logic              w_calc;
  logic              w_err;
  logic              w_fin;
  logic              w_nxt;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs2_val;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic              w_md_done;
  logic              w_md_busy;
  logic [DATA_W-1:0] w_md_result;

  assign w_op      = r_ir.opcode;
  assign w_imm     = DATA_W'(r_ir.imm);
  assign w_rs2_val = r_rf[r_ir.imm[1:0]];
  assign w_is_md   = c_MD_EN && (w_op == OP_MUL || w_op == OP_DIV);
  assign w_legal   = (w_op inside {OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_JMP, OP_HALT}) || w_is_md;
  assign w_writes  = w_legal && (w_op inside {OP_LDI, OP_ADD, OP_SUB, OP_MUL, OP_DIV});

  // Completion flags only exist in SCALC; priority err > finish > nxt_line.
  assign w_calc = (seq_q == SCALC);
  assign w_err  = w_calc && (!w_legal || (w_is_md && w_op == OP_DIV && r_opb == '0));
  assign w_fin  = w_calc && !w_err && (w_op == OP_HALT);
  assign w_nxt  = w_calc && !w_err && !w_fin && (!w_is_md || (w_md_done && !w_md_busy));

  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_LDI:  w_alu = r_opb;
      OP_ADD:  w_alu = r_opa + r_opb;
      OP_SUB:  w_alu = r_opa - r_opb;
      default: w_alu = '0;
    endcase
  end

  assign w_result = w_is_md ? w_md_result : w_alu;

`ifdef EXEC_MULDIV_EN
  logic w_md_start;
  logic w_md_clr;

  assign w_md_start = (seq_q == SLOAD2) && w_is_md;
  assign w_md_clr   = (seq_q == SRST) || (seq_q == SWRITE);

  exec_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .rstn   (rstn),
    .start  (w_md_start),
    .is_div (w_op == OP_DIV),
    .step   (w_calc),
    .clr    (w_md_clr),
    .a      (r_opa),
    .b      (w_rs2_val),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .result (w_md_result)
  );
`else
  assign w_md_busy   = 1'b0;
  assign w_md_done   = 1'b0;
  assign w_md_result = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_opa <= '0;
      r_opb <= '0;
      r_res <= '0;
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
    end else begin
      case (seq_q)
        SRST: begin
          r_pc <= '0;
          r_ir <= '0;
        end
        SREAD:  r_ir  <= instr_t'(imem_data);
        SLOAD1: r_opa <= r_rf[r_ir.rs1];
        SLOAD2: r_opb <= (w_op == OP_LDI || w_op == OP_JMP) ? w_imm : w_rs2_val;
        SCALC: begin
          if (w_nxt) r_res <= w_result;
        end
        SWRITE: begin
          if (w_writes) r_rf[r_ir.rd] <= r_res;
          r_pc <= (w_op == OP_JMP) ? ADDR_W'(r_opb) : r_pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign nxt_line  = w_nxt;
  assign err       = w_err;
  assign finish    = w_fin;
  assign dbg_data  = r_rf[dbg_sel];

endmodule

`default_nettype wire

// File: doc/exec_controller.md
Name: exec_controller

Overview:
- Datapath/control counterpart to the CPU sequencer.
- Consumes the sequencer state and drives the sequencer's nxt_line, err and finish inputs.
- Owns the program counter, instruction register, 4-entry register file and ALU, including iterative multiply/divide that holds the sequencer in SCALC.
- Fetches 16-bit instructions from an external asynchronous-read instruction memory.

Parameters:
- DATA_W, 8: register and ALU width.
- ADDR_W, 4: program counter / instruction memory address width (16 lines).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- seq_q  in  SequencerState  current sequencer state
- imem_addr  out  ADDR_W  instruction address; equals pc
- imem_data  in  16  instruction word; asynchronous read of imem_addr
- nxt_line  out  1  current instruction complete; sequencer leaves SCALC for SWRITE
- err  out  1  illegal opcode or divide-by-zero
- finish  out  1  HALT executed
- dbg_sel  in  2  register file debug read select
- dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Reset values: pc=0, ir=0, opA=0, opB=0, all regs=0, mul/div counter=0, done=0. nxt_line, err and finish are 0, because they are gated by seq_q==SCALC, which is never true in SRST.
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs1, [7:0] imm. rs2 is imm[1:0].
- Opcodes:
  - 0 NOP
  - 1 LDI: rd=imm
  - 2 ADD: rd=rs1+rs2, mod 2^DATA_W
  - 3 SUB: rd=rs1-rs2, mod 2^DATA_W
  - 4 MUL: low DATA_W bits
  - 5 DIV: quotient, unsigned
  - 6 JMP: pc=imm[ADDR_W-1:0]
  - F HALT
  - all others illegal
- SRST: pc=0, ir=0, done=0. The register file keeps its contents; only rstn clears it.
- SREAD: ir<=imem_data at the clock edge ending SREAD.
- SLOAD1: opA<=reg[rs1].
- SLOAD2: opB<=reg[rs2], or imm for LDI/JMP. Clears the counter. Multiply/divide working registers are initialised.
- SCALC, single-cycle ops (NOP, LDI, ADD, SUB, JMP):
  - Result is computed combinationally.
  - nxt_line=1 combinationally in the first SCALC cycle.
  - Result is latched at that edge.
- SCALC, MUL: shift-add, one bit per cycle. done set after DATA_W iterations; nxt_line=1 in SCALC cycle DATA_W+1 (9 cycles at DATA_W=8).
- SCALC, DIV: restoring division, same cycle count and done timing as MUL.
- err (combinational, SCALC only): illegal opcode, or DIV with opB==0. Asserted in the first SCALC cycle. nxt_line stays 0 while err=1.
- finish (combinational, SCALC only): HALT in the first SCALC cycle. nxt_line=0.
- Priority when several apply: err > finish > nxt_line.
- SWRITE:
  - rd<=result for LDI/ADD/SUB/MUL/DIV.
  - pc<=jump target for JMP, else pc+1. pc wraps 2^ADDR_W-1 -> 0 with no error.
  - done cleared.
- SFINISH, SERR: all state frozen; outputs 0.
- Any unlisted seq_q value: hold all state.
- rstn low mid-MUL/DIV: all state clears immediately; no partial write occurs.
- dbg_data is always a live combinational read.

Optional Feature:
- Macro EXEC_MULDIV_EN.
- Defined: MUL/DIV execute as described and the iterative unit is instantiated.
- Undefined: opcodes 4 and 5 are illegal and raise err in the first SCALC cycle. No iterative hardware is built.

Decomposition:
- params.svh holds:
  - SequencerState (already shared)
  - Opcode enum
  - Instruction packed struct (opcode, rd, rs1, imm)
  - DATA_W/ADDR_W defaults
- Sub-module exec_muldiv: iterative unsigned shift-add multiplier / restoring divider.
  - Interface: start, is_div, a, b, busy, done, result.
  - Instantiated only under EXEC_MULDIV_EN.

Test Plan:
- Program LDI r0,25; LDI r1,17; ADD r2,r0,r1; HALT. Drive the full state sequence. Expect:
  - dbg r2=42
  - nxt_line on the first SCALC cycle of each non-HALT instruction
  - finish on HALT's first SCALC cycle
  - pc=3 at HALT
- LDI r0,12; LDI r1,11; MUL r2 (EXEC_MULDIV_EN) -> nxt_line exactly 9 cycles after SCALC entry; r2=132. SUB r3=r1-r0 -> 255 (wrap).
- DIV r0=100, r1=7 -> r2=14 after 9 SCALC cycles. DIV with r1=0 -> err=1 in the first SCALC cycle and nxt_line=0.
- Opcode 0x7, or MUL without EXEC_MULDIV_EN -> err=1 in the first SCALC cycle; no register write.
- 16 NOPs starting at pc=15 -> after SWRITE pc=0. JMP imm=5 -> imem_addr=5 in the next SREAD.
- Assert rstn low in the 4th SCALC cycle of MUL -> pc, regs, counter and outputs go to 0 immediately; no register is written.
